// File: rtl/hh_stim_scheduler.sv
// Round-robin scheduler sharing one Hodgkin-Huxley datapath among NUM_CH stimulus streams,
// with tag/result FIFOs and credit flow control. Define HH_SCHED_PRIO0_EN for channel-0 priority.
module hh_stim_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DEPTH  = 8,
  localparam int unsigned CH_W  = $clog2(NUM_CH),
  localparam int unsigned CRW   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [32*NUM_CH-1:0] s_data,
  input  logic [NUM_CH-1:0]    s_valid,
  output logic [NUM_CH-1:0]    s_ready,
  output logic [31:0]          hh_s,
  output logic                 hh_valid,
  input  logic                 hh_rdy,
  input  logic [31:0]          hh_V,
  input  logic                 hh_o_valid,
  output logic [31:0]          m_data,
  output logic [CH_W-1:0]      m_channel,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [CRW-1:0]       o_credits,
  output logic                 o_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = CH_W + 32;

  logic [CH_W-1:0] rr_q;
  logic [CRW-1:0]  credits_q;
  logic            err_q;

  logic [CH_W-1:0] tag_mem [DEPTH];
  logic [AW-1:0]   tag_wr_q, tag_rd_q;
  logic [AW:0]     tag_cnt_q;

  logic [RW-1:0]   res_mem [DEPTH];
  logic [AW-1:0]   res_wr_q, res_rd_q;
  logic [AW:0]     res_cnt_q;
  logic [RW-1:0]   res_head;

  logic [CH_W-1:0] grant, cand;
  logic            any_req;
  logic            issue, rr_upd;
  logic            tag_pop, res_pop, err_set;

  // Search upward from rr_q with wrap; first requesting channel wins.
  always_comb begin
    grant   = '0;
    cand    = '0;
    any_req = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_q) + 32'(i)) % NUM_CH);
      if (!any_req && s_valid[cand]) begin
        any_req = 1'b1;
        grant   = cand;
      end
    end
`ifdef HH_SCHED_PRIO0_EN
    if (s_valid[0]) begin
      any_req = 1'b1;
      grant   = '0;
    end
`endif
  end

  // Gated by reset_n so the handshake outputs read zero while reset is held.
  assign issue = reset_n && hh_rdy && (credits_q != '0) && any_req;

`ifdef HH_SCHED_PRIO0_EN
  assign rr_upd = issue && !s_valid[0];
`else
  assign rr_upd = issue;
`endif

  assign s_ready  = issue ? (NUM_CH'(1) << grant) : '0;
  assign hh_valid = issue;
  assign hh_s     = issue ? s_data[{grant, 5'b0} +: 32] : '0;

  assign tag_pop  = hh_o_valid && (tag_cnt_q != '0);
  assign err_set  = hh_o_valid && (tag_cnt_q == '0);

  assign res_head  = res_mem[res_rd_q];
  assign m_valid   = (res_cnt_q != '0);
  assign res_pop   = m_valid && m_ready;
  assign m_data    = m_valid ? res_head[31:0] : '0;
  assign m_channel = m_valid ? res_head[RW-1:32] : '0;

  assign o_credits = credits_q;
  assign o_err     = err_q;

  always_ff @(posedge clk) begin
    if (issue) tag_mem[tag_wr_q] <= grant;
    if (tag_pop) res_mem[res_wr_q] <= {tag_mem[tag_rd_q], hh_V};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q      <= '0;
      credits_q <= CRW'(DEPTH);
      err_q     <= 1'b0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (rr_upd) rr_q <= CH_W'((32'(grant) + 32'd1) % NUM_CH);
      credits_q <= credits_q - {{(CRW-1){1'b0}}, issue} + {{(CRW-1){1'b0}}, res_pop};
      if (err_set) err_q <= 1'b1;
      if (issue)   tag_wr_q <= tag_wr_q + AW'(1);
      if (tag_pop) tag_rd_q <= tag_rd_q + AW'(1);
      tag_cnt_q <= tag_cnt_q + {{AW{1'b0}}, issue} - {{AW{1'b0}}, tag_pop};
      if (tag_pop) res_wr_q <= res_wr_q + AW'(1);
      if (res_pop) res_rd_q <= res_rd_q + AW'(1);
      res_cnt_q <= res_cnt_q + {{AW{1'b0}}, tag_pop} - {{AW{1'b0}}, res_pop};
    end
  end

endmodule

// File: tb/tb_hh_stim_scheduler.sv
// Directed bench for hh_stim_scheduler (NUM_CH=4, DEPTH=8) with a 5-cycle datapath model.
module tb_hh_stim_scheduler;

  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] s_data;
  logic [3:0]   s_valid;
  logic [3:0]   s_ready;
  logic [31:0]  hh_s;
  logic         hh_valid;
  logic         hh_rdy;
  logic [31:0]  hh_V;
  logic         hh_o_valid;
  logic [31:0]  m_data;
  logic [1:0]   m_channel;
  logic         m_valid;
  logic         m_ready;
  logic [3:0]   o_credits;
  logic         o_err;

  logic         dp_en;
  logic         force_ov;
  logic [31:0]  force_v;
  logic [4:0]   pipe_v;
  logic [31:0]  pipe_d [5];
  logic [23:0]  seq [4];
  logic [23:0]  n_out [4];

  int checks = 0;
  int errors = 0;
  int cnt, n_iss, n_pop, exp_g, exp_c;

  hh_stim_scheduler #(.NUM_CH(4), .DEPTH(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .hh_s       (hh_s),
    .hh_valid   (hh_valid),
    .hh_rdy     (hh_rdy),
    .hh_V       (hh_V),
    .hh_o_valid (hh_o_valid),
    .m_data     (m_data),
    .m_channel  (m_channel),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .o_credits  (o_credits),
    .o_err      (o_err)
  );

  always #5 clk = ~clk;

  // Channel k presents {k, running sequence number}.
  always_comb begin
    s_data = '0;
    for (int k = 0; k < 4; k++) s_data[32*k +: 32] = {8'(k), seq[k]};
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) if (s_ready[k]) seq[k] <= seq[k] + 24'd1;
  end

  // Datapath model: fixed 5-cycle latency, result = stimulus ^ K.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_v <= '0;
      for (int i = 0; i < 5; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v <= {pipe_v[3:0], hh_valid & hh_rdy & dp_en};
      pipe_d[0] <= hh_s ^ K;
      for (int i = 1; i < 5; i++) pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign hh_o_valid = force_ov | (dp_en & pipe_v[4]);
  assign hh_V       = force_ov ? force_v : pipe_d[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      seq[k]   = '0;
      n_out[k] = '0;
    end
    reset_n = 1'b0; s_valid = '0; hh_rdy = 1'b1; m_ready = 1'b1;
    dp_en = 1'b1; force_ov = 1'b0; force_v = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_credits", o_credits, 8);
    check("rst_mvalid", m_valid, 0);
    check("rst_err", o_err, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Round-robin with all channels requesting and sink always ready.
    s_valid = 4'hF;
    n_iss = 0; n_pop = 0; exp_g = 0; exp_c = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (hh_valid) begin
        check("rr_grant", s_ready, 32'(1) << exp_g);
        exp_g = (exp_g + 1) % 4;
        n_iss++;
      end
      if (m_valid) begin
        check("rr_chan", m_channel, exp_c);
        check("rr_data", m_data, {8'(exp_c), n_out[exp_c]} ^ K);
        n_out[exp_c] = n_out[exp_c] + 24'd1;
        exp_c = (exp_c + 1) % 4;
        n_pop++;
      end
      @(negedge clk);
    end
    s_valid = '0;
    check("rr_issues", n_iss, 40);
    check("rr_pops", n_pop, 34);
    repeat (15) @(negedge clk);
    #1;
    check("drain_credits", o_credits, 8);

    // Credit exhaustion with the sink stalled.
    m_ready = 1'b0; s_valid = 4'hF; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (hh_valid) cnt++;
      @(negedge clk);
    end
    #1;
    check("exh_issues", cnt, 8);
    check("exh_sready", s_ready, 0);
    check("exh_credits", o_credits, 0);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (hh_valid) cnt++;
      @(negedge clk);
    end
    #1;
    check("exh_one_more", cnt, 1);
    check("exh_credits2", o_credits, 0);
    s_valid = '0; m_ready = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check("exh_drain", o_credits, 8);
    check("exh_mvalid", m_valid, 0);

    // Sparse requests: channel 2 then channel 1 (pointer wraps 3->0->1).
    @(negedge clk);
    s_valid = 4'b0100;
    #1;
    check("sp_grant2", s_ready, 4'b0100);
    check("sp_hh_s_ch", hh_s[31:24], 2);
    @(negedge clk);
    s_valid = 4'b0010;
    #1;
    check("sp_grant1", s_ready, 4'b0010);
    @(negedge clk);
    s_valid = '0;
    #1;
    check("sp_idle", s_ready, 0);
    check("sp_idle_v", hh_valid, 0);
    repeat (10) @(negedge clk);

    // Simultaneous issue, result return and pop with credits=3.
    dp_en = 1'b0; m_ready = 1'b0; s_valid = 4'b0001;
    repeat (5) @(negedge clk);
    s_valid = '0;
    #1;
    check("sim_pre_cr", o_credits, 3);
    force_ov = 1'b1; force_v = 32'hAAAA_0001;
    @(negedge clk);
    force_v = 32'hAAAA_0002;
    @(negedge clk);
    force_ov = 1'b0;
    #1;
    check("sim_cr_before", o_credits, 3);
    check("sim_head_a", m_data, 32'hAAAA_0001);
    s_valid = 4'b0001; force_ov = 1'b1; force_v = 32'hAAAA_0003; m_ready = 1'b1;
    #1;
    check("sim_issue", hh_valid, 1);
    @(negedge clk);
    s_valid = '0; force_ov = 1'b0; m_ready = 1'b0;
    #1;
    check("sim_cr_after", o_credits, 3);
    check("sim_head_b", m_data, 32'hAAAA_0002);
    m_ready = 1'b1; cnt = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (m_valid) cnt++;
      @(negedge clk);
    end
    check("sim_res_occ", cnt, 2);
    #1;
    check("sim_cr_5", o_credits, 5);
    force_ov = 1'b1;
    repeat (3) @(negedge clk);
    force_ov = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("sim_tag_occ", o_credits, 8);
    check("sim_no_err", o_err, 0);

    // Result with no outstanding tag.
    force_ov = 1'b1; force_v = 32'hDEAD_BEEF;
    @(negedge clk);
    force_ov = 1'b0;
    #1;
    check("err_set", o_err, 1);
    check("err_mvalid", m_valid, 0);
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", o_err, 1);

    // Reset mid-stream with 3 results buffered.
    m_ready = 1'b0; s_valid = 4'b0001;
    repeat (3) @(negedge clk);
    s_valid = '0; force_ov = 1'b1;
    repeat (3) @(negedge clk);
    force_ov = 1'b0;
    #1;
    check("mr_buffered", o_credits, 5);
    reset_n = 1'b0; s_valid = 4'hF;
    @(negedge clk);
    #1;
    check("mr_mvalid", m_valid, 0);
    check("mr_credits", o_credits, 8);
    check("mr_err", o_err, 0);
    check("mr_sready", s_ready, 0);
    check("mr_hhvalid", hh_valid, 0);
    check("mr_hh_s", hh_s, 0);
    check("mr_mdata", m_data, 0);
    check("mr_mchan", m_channel, 0);
    reset_n = 1'b1;
    #1;
    check("mr_rr0", s_ready, 4'b0001);
    @(negedge clk);
    s_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hh_stim_scheduler.md
# hh_stim_scheduler

Time-multiplexes a single Hodgkin-Huxley datapath among NUM_CH independent stimulus streams. Grants one stimulus beat per cycle, round-robin. Tags each issued beat with its channel ID and returns each membrane-voltage result on one merged output stream carrying that ID. A credit counter bounds in-flight work, so results are never lost: the datapath output has no backpressure. Sits between the per-neuron stimulus FIFOs and the hodgkin_huxley instance inside the multi-neuron core.

## Interface
Parameters:
- NUM_CH, 4: number of requesting channels (2..16).
- DEPTH, 8: result buffer depth and credit pool size (power of 2, ≥2).
- CH_W, $clog2(NUM_CH): channel ID width (derived, not overridden).

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- s_data  in  32*NUM_CH  stimulus per channel; channel k at [32k+31:32k].
- s_valid  in  NUM_CH  per-channel stimulus valid.
- s_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- hh_s  out  32  stimulus to datapath.
- hh_valid  out  1  stimulus valid to datapath.
- hh_rdy  in  1  datapath can accept.
- hh_V  in  32  datapath result.
- hh_o_valid  in  1  result valid; cannot be stalled.
- m_data  out  32  merged result.
- m_channel  out  CH_W  channel ID of m_data.
- m_valid  out  1  result available.
- m_ready  in  1  downstream accept.
- o_credits  out  $clog2(DEPTH)+1  free credits.
- o_err  out  1  sticky: result arrived with no outstanding tag.

## Operation
- Issue condition: hh_rdy && credits>0 && |s_valid.
- Grant: first channel with s_valid set, searching from rr_ptr upward with wrap (mod NUM_CH).
- On issue to channel g:
  - s_ready[g]=1 and hh_valid=1.
  - hh_s = s_data of channel g.
  - g pushed into the tag FIFO (depth DEPTH).
  - rr_ptr <= (g+1) mod NUM_CH.
  - credits decremented.
- No issue: s_ready=0, hh_valid=0, rr_ptr unchanged.
- On hh_o_valid:
  - If the tag FIFO is non-empty, pop the tag and write {tag, hh_V} into the result FIFO (depth DEPTH). The result FIFO cannot overflow because credits cover both FIFOs.
  - If the tag FIFO is empty, drop the result and set o_err. o_err clears only on reset.
- Output: m_valid = result FIFO non-empty. m_data/m_channel show the head entry (first-word fall-through). An entry pops on m_valid && m_ready. The credit is returned on that pop.
- Credit arithmetic: credits = DEPTH − (tags outstanding + results buffered).
  - Issue and pop in the same cycle: credits unchanged.
  - Credits never exceed DEPTH and never drop below 0.
- Simultaneous tag push (issue) and tag pop (hh_o_valid) in one cycle are both honoured. The same holds for result FIFO write and read.
- Reset (any time, including mid-operation):
  - FIFOs flushed, rr_ptr=0, credits=DEPTH, o_err=0.
  - All outputs 0: s_ready, hh_valid, hh_s, m_valid, m_data, m_channel.
  - The datapath shares reset_n, so no stale results follow.

## Timing
- Grant is combinational. Stimulus reaches hh_s/hh_valid in the same cycle as s_valid when the issue condition holds.
- Result latency: hh_o_valid at cycle t → m_valid at t+1 (registered FIFO write), provided the FIFO was empty.
- Throughput: one issue per cycle and one result per cycle sustained while credits>0 and m_ready=1.
- With m_ready held low, at most DEPTH beats issue before s_ready stays 0.
- rr_ptr update and credit update take effect the cycle after the event.
- o_err asserts the cycle after the offending hh_o_valid.

## Configuration
- HH_SCHED_PRIO0_EN defined: channel 0 has strict priority. When s_valid[0]=1 and the issue condition holds, channel 0 is granted and rr_ptr is not modified. Round-robin applies among channels 1..NUM_CH-1 only when s_valid[0]=0.
- Undefined: pure round-robin across all channels as above.

## Test plan
- Reset values: assert reset_n=0 mid-stream with 3 results buffered → next cycle m_valid=0, o_credits=8, o_err=0, s_ready=0.
- Round-robin fairness: NUM_CH=4, all s_valid=1, hh_rdy=1, m_ready=1, datapath latency 5 → grants 0,1,2,3,0,1…; m_channel sequence matches; each m_data equals a model of that channel's stimulus.
- Credit exhaustion: m_ready=0, all channels valid → exactly 8 issues, then s_ready=0 and o_credits=0. Raise m_ready for one cycle → exactly one further issue.
- Sparse requests: only s_valid[2]=1, then only s_valid[1] → grant 2, then 1 with rr_ptr wrap; no grant to idle channels.
- Simultaneous events: issue, hh_o_valid, and m_ready pop in the same cycle with credits=3 → credits stay 3; tag FIFO and result FIFO occupancies correct.
- Error: pulse hh_o_valid with no outstanding tags → o_err=1 next cycle, m_valid stays 0, o_err persists until reset_n=0.
